alu_seq: RTL and testbench

- Parametrised, handshaked successor to the 16-bit combinational Hack-style ALU.
- Keeps the zx/nx/zy/ny/f/no control semantics and the zr/ng flags, generalised to WIDTH bits.
- Adds a registered output stage with valid/ready flow control and a multi-cycle shift-add multiply mode.
- Sits between the operand/decode stage and the writeback stage of the CPU datapath.

---
 rtl/alu_seq.sv | 206 ++++++++++++++++++++
 tb/tb_alu_seq.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// ---------------------------------------------------------------------------
// alu_seq -- handshaked, registered successor to the Hack combinational ALU.
//
// The zx/nx/zy/ny/f/no control semantics and the zr/ng flags are kept and
// widened to WIDTH bits. Results go into an output register with valid/ready
// flow control. Setting mul selects a multi-cycle unsigned shift-add multiply
// that keeps the low WIDTH bits of the product.
//
// Parameters:
//   WIDTH  operand/result width in bits (>= 2)
//   CNT_W  width of the multiply step counter
//
// Ports:
//   clk, rst              clock; synchronous active-high reset
//   in_valid / in_ready   operand handshake (in_ready is combinational)
//   x, y                  operands
//   zx nx zy ny f no      Hack control bits
//   mul                   1 = multiply (f is ignored)
//   out_valid / out_ready result handshake
//   out, zr, ng           registered result, zero flag, sign flag
//   busy                  a multiply is in progress
//
// Optional build macro ALU_OVF_FLAGS_EN adds registered carry and ov outputs
// and widens the multiply accumulator to 2*WIDTH bits so ov can see the
// discarded upper half of the product.
// ---------------------------------------------------------------------------
module alu_seq #(
  parameter int WIDTH = 16,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             zx,
  input  logic             nx,
  input  logic             zy,
  input  logic             ny,
  input  logic             f,
  input  logic             no,
  input  logic             mul,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             zr,
  output logic             ng,
`ifdef ALU_OVF_FLAGS_EN
  output logic             carry,
  output logic             ov,
`endif
  output logic             busy
);

`ifdef ALU_OVF_FLAGS_EN
  localparam int ACC_W = 2 * WIDTH;
`else
  localparam int ACC_W = WIDTH;
`endif

  typedef enum logic {
    IDLE,
    MUL
  } state_t;

  state_t state, state_next;

  logic [WIDTH-1:0] xp, yp;
  logic [WIDTH-1:0] hack_r;
  logic [WIDTH-1:0] mul_r;
  logic             accept;
  logic             mul_done;

  // Multiply working registers: the multiplicand shifts left and the
  // multiplier shifts right each step, so bit 0 of the multiplier always
  // decides whether the current partial product is added.
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic             mno;
  logic [CNT_W-1:0] cnt;

`ifdef ALU_OVF_FLAGS_EN
  logic [WIDTH:0]   sum;
  logic             hack_carry;
  logic             hack_ov;
  logic             mul_ov;
`else
  logic [WIDTH-1:0] sum;
`endif

  // A new operation may enter only when idle and the output register is
  // either empty or being drained on this same edge.
  assign in_ready = (state == IDLE) && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign busy     = (state == MUL);
  // The final edge of a multiply comes after all WIDTH steps have run.
  assign mul_done = (state == MUL) && (cnt == CNT_W'(WIDTH));

  // Operand preprocessing: optional zeroing followed by optional inversion.
  always_comb begin
    xp = zx ? '0 : x;
    if (nx) xp = ~xp;
    yp = zy ? '0 : y;
    if (ny) yp = ~yp;
  end

  // Single-cycle Hack function. Carry and overflow describe the adder
  // before the optional output inversion.
  always_comb begin
`ifdef ALU_OVF_FLAGS_EN
    sum        = {1'b0, xp} + {1'b0, yp};
    hack_carry = f & sum[WIDTH];
    hack_ov    = f & (xp[WIDTH-1] == yp[WIDTH-1]) & (sum[WIDTH-1] != xp[WIDTH-1]);
`else
    sum        = xp + yp;
`endif
    hack_r = f ? sum[WIDTH-1:0] : (xp & yp);
    if (no) hack_r = ~hack_r;
  end

  // Final multiply result from the low half of the accumulator.
  always_comb begin
    mul_r = mno ? ~acc[WIDTH-1:0] : acc[WIDTH-1:0];
`ifdef ALU_OVF_FLAGS_EN
    mul_ov = |acc[ACC_W-1:WIDTH];
`endif
  end

  // Control state register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic: stay in MUL until the result has been loaded.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept && mul) state_next = MUL;
      MUL:     if (mul_done) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Multiply datapath: capture operands on accept, then one shift-add step
  // per cycle. Reset mid-multiply discards the partial product.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      mno    <= 1'b0;
      cnt    <= '0;
    end else if (accept && mul) begin
      acc    <= '0;
      mcand  <= ACC_W'(xp);
      mplier <= yp;
      mno    <= no;
      cnt    <= '0;
    end else if ((state == MUL) && !mul_done) begin
      if (mplier[0]) acc <= acc + mcand;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + CNT_W'(1);
    end
  end

  // Output register: loads a Hack result on accept or a product when the
  // multiply completes; otherwise holds until the consumer takes it. Flags
  // only change together with out.
  always_ff @(posedge clk) begin
    if (rst) begin
      out       <= '0;
      zr        <= 1'b0;
      ng        <= 1'b0;
      out_valid <= 1'b0;
`ifdef ALU_OVF_FLAGS_EN
      carry     <= 1'b0;
      ov        <= 1'b0;
`endif
    end else if (accept && !mul) begin
      out       <= hack_r;
      zr        <= (hack_r == '0);
      ng        <= hack_r[WIDTH-1];
      out_valid <= 1'b1;
`ifdef ALU_OVF_FLAGS_EN
      carry     <= hack_carry;
      ov        <= hack_ov;
`endif
    end else if (mul_done) begin
      out       <= mul_r;
      zr        <= (mul_r == '0);
      ng        <= mul_r[WIDTH-1];
      out_valid <= 1'b1;
`ifdef ALU_OVF_FLAGS_EN
      carry     <= 1'b0;
      ov        <= mul_ov;
`endif
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// ---------------------------------------------------------------------------
// tb_alu_seq -- self-checking bench for alu_seq (WIDTH = 16).
// Expected results come from a behavioural model using plain arithmetic and
// are queued when an operation is accepted; an independent monitor pops and
// compares whenever the DUT hands over a result.
// ---------------------------------------------------------------------------
module tb_alu_seq;

  localparam int W  = 16;
  localparam int W2 = 2 * W;
  localparam int BUDGET = 100;

  typedef struct packed {
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic zx, nx, zy, ny, f, no, mul;
  } op_t;

  typedef struct packed {
    logic [W-1:0] out;
    logic zr, ng, carry, ov;
  } res_t;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] x, y;
  logic         zx, nx, zy, ny, f, no, mul;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out;
  logic         zr, ng;
  logic         busy;
`ifdef ALU_OVF_FLAGS_EN
  logic         carry, ov;
`endif

  int   n_vec = 0;
  int   n_err = 0;
  int   ready_mode = 1;
  res_t sb[$];

  alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .y(y),
    .zx(zx), .nx(nx), .zy(zy), .ny(ny), .f(f), .no(no), .mul(mul),
    .out_valid(out_valid), .out_ready(out_ready),
    .out(out), .zr(zr), .ng(ng),
`ifdef ALU_OVF_FLAGS_EN
    .carry(carry), .ov(ov),
`endif
    .busy(busy)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Consumer: 0 = stall, 1 = always ready, 2 = random; applied 2 time units
  // after each rising edge so it is stable over the sampling negedge.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      case (ready_mode)
        0:       out_ready = 1'b0;
        1:       out_ready = 1'b1;
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Reference model: the control-bit rules evaluated with plain arithmetic.
  function automatic res_t model(input op_t op);
    res_t          r;
    logic [W-1:0]  xp, yp, v;
    logic [W2-1:0] prod;
    logic [W:0]    s;
    int            ssum;
    r  = '0;
    xp = op.zx ? '0 : op.x;
    if (op.nx) xp = ~xp;
    yp = op.zy ? '0 : op.y;
    if (op.ny) yp = ~yp;
    if (op.mul) begin
      prod = W2'(xp) * W2'(yp);
      v    = prod[W-1:0];
      r.ov = (prod >> W) != 0;
    end else if (op.f) begin
      s       = (W+1)'(xp) + (W+1)'(yp);
      v       = s[W-1:0];
      r.carry = s[W];
      ssum    = int'($signed(xp)) + int'($signed(yp));
      r.ov    = (ssum > 32767) || (ssum < -32768);
    end else begin
      v = xp & yp;
    end
    if (op.no) v = ~v;
    r.out = v;
    r.zr  = (v == '0);
    r.ng  = v[W-1];
`ifndef ALU_OVF_FLAGS_EN
    r.carry = 1'b0;
    r.ov    = 1'b0;
`endif
    return r;
  endfunction

  function automatic res_t sampleDut();
    res_t a;
    a.out = out;
    a.zr  = zr;
    a.ng  = ng;
`ifdef ALU_OVF_FLAGS_EN
    a.carry = carry;
    a.ov    = ov;
`else
    a.carry = 1'b0;
    a.ov    = 1'b0;
`endif
    return a;
  endfunction

  function automatic op_t mk(input logic [W-1:0] ax, input logic [W-1:0] ay,
                             input logic [6:0] c);
    op_t op;
    op.x = ax;
    op.y = ay;
    {op.zx, op.nx, op.zy, op.ny, op.f, op.no, op.mul} = c;
    return op;
  endfunction

  function automatic op_t randomOp(input bit allow_mul);
    op_t op;
    op = mk(W'($urandom_range(0, 65535)), W'($urandom_range(0, 65535)),
            7'($urandom_range(0, 127)));
    op.mul = allow_mul && ($urandom_range(0, 4) == 0);
    return op;
  endfunction

  task automatic checkOutput(input string name, input res_t act, input res_t exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got out=%h zr=%b ng=%b carry=%b ov=%b, expected out=%h zr=%b ng=%b carry=%b ov=%b",
               name, act.out, act.zr, act.ng, act.carry, act.ov,
               exp.out, exp.zr, exp.ng, exp.carry, exp.ov);
    end
  endtask

  task automatic checkValue(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic driveOp(input op_t op);
    x = op.x; y = op.y;
    {zx, nx, zy, ny, f, no, mul} = {op.zx, op.nx, op.zy, op.ny, op.f, op.no, op.mul};
    in_valid = 1'b1;
  endtask

  // Offer an operation until accepted; the expected result is queued at the
  // accepting edge. Returns with time at 1 unit after a rising edge.
  task automatic applyStimulus(input op_t op, output int waited);
    bit ok;
    ok = 1'b0;
    waited = 0;
    driveOp(op);
    for (int i = 0; i < BUDGET; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
      waited++;
    end
    if (ok) sb.push_back(model(op));
    else begin
      n_vec++;
      n_err++;
      $display("[TB] FAIL accept_timeout: in_ready stayed 0 for %0d cycles, expected 1", BUDGET);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic waitDrain();
    for (int i = 0; i < 4 * BUDGET; i++) begin
      if (sb.size() == 0) break;
      @(posedge clk);
      #1;
    end
    if (sb.size() != 0) begin
      n_vec++;
      n_err++;
      $display("[TB] FAIL drain_timeout: %0d results outstanding, expected 0", sb.size());
    end
  endtask

  // Monitor: every handed-over result is compared with the queue head.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && out_valid && out_ready) begin
        if (sb.size() == 0) begin
          n_vec++;
          n_err++;
          $display("[TB] FAIL unexpected_result: got out=%h with nothing expected", out);
        end else begin
          checkOutput("result", sampleDut(), sb.pop_front());
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int   w, cyc, bad, tot;
    res_t r, held;
    op_t  mop, hop;

    rst = 1'b1; in_valid = 1'b0; x = '0; y = '0;
    {zx, nx, zy, ny, f, no, mul} = '0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_out", sampleDut(), '0);
    checkValue("reset_valid", int'(out_valid), 0);
    checkValue("reset_busy", int'(busy), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // x + y with one-cycle latency
    applyStimulus(mk(16'h0002, 16'h0001, 7'b0000100), w);
    @(negedge clk);
    r = '0;
    r.out = 16'h0003;
    checkOutput("add_2_1", sampleDut(), r);
    checkValue("add_latency_valid", int'(out_valid), 1);
    @(posedge clk);
    #1;

    // Zeroed add, x - y, and the overflow-flag cases
    applyStimulus(mk(16'h0002, 16'h0001, 7'b1010100), w);
    applyStimulus(mk(16'h0002, 16'h0004, 7'b0100110), w);
    applyStimulus(mk(16'h7FFF, 16'h0001, 7'b0000100), w);
    applyStimulus(mk(16'hFFFF, 16'h0001, 7'b0000100), w);
    applyStimulus(mk(16'h0100, 16'h0100, 7'b0000001), w);
    waitDrain();

    // Multiply latency and busy/in_ready during the operation
    applyStimulus(mk(16'd7, 16'd6, 7'b0000001), w);
    cyc = 0;
    bad = 0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (out_valid) break;
      cyc++;
      if (!busy || in_ready) bad++;
    end
    checkValue("mul_latency", cyc, W + 1);
    checkValue("mul_busy_cycles_bad", bad, 0);
    checkValue("mul_busy_after", int'(busy), 0);
    r = '0;
    r.out = 16'h002A;
    checkOutput("mul_7x6", sampleDut(), r);
    @(posedge clk);
    #1;
    waitDrain();

    // Output hold under back-pressure blocks the next operation
    ready_mode = 0;
    mop = mk(16'h0003, 16'h0005, 7'b0000011);
    hop = mk(16'h1234, 16'h0F0F, 7'b0000000);
    applyStimulus(mop, w);
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (out_valid) break;
    end
    held = sampleDut();
    checkOutput("held_value", held, model(mop));
    @(posedge clk);
    #1;
    driveOp(hop);
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (in_ready || !out_valid || (sampleDut() !== held)) bad++;
      @(posedge clk);
      #1;
    end
    checkValue("hold_cycles_bad", bad, 0);
    ready_mode = 1;
    applyStimulus(hop, w);
    checkValue("unblock_wait", w, 0);
    waitDrain();

    // Back-to-back Hack ops: one accepted per cycle
    tot = 0;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(randomOp(1'b0), w);
      tot += w;
    end
    checkValue("throughput_stalls", tot, 0);
    waitDrain();

    // Reset in the middle of a multiply
    applyStimulus(randomOp(1'b0) | op_t'(1), w);
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    void'(sb.pop_back());
    @(negedge clk);
    checkOutput("rst_mid_out", sampleDut(), '0);
    checkValue("rst_mid_valid", int'(out_valid), 0);
    checkValue("rst_mid_busy", int'(busy), 0);
    checkValue("rst_mid_ready", int'(in_ready), 1);
    @(posedge clk);
    #1;
    applyStimulus(randomOp(1'b0), w);
    checkValue("rst_next_accept_wait", w, 0);
    waitDrain();

    // Randomised traffic with a random consumer
    ready_mode = 2;
    for (int i = 0; i < 150; i++) begin
      int gap;
      applyStimulus(randomOp(1'b1), w);
      gap = $urandom_range(0, 2);
      repeat (gap) begin
        @(posedge clk);
        #1;
      end
    end
    ready_mode = 1;
    waitDrain();
    checkValue("scoreboard_empty", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
